// File: rtl/dispatch4way_if.sv
// Handshake bundle for dispatch4way: one upstream port, four downstream channels,
// routing controls and the accepted-word counter.
interface dispatch4way_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [1:0]       in_sel;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a, b, c, d;
    logic             a_valid, b_valid, c_valid, d_valid;
    logic             a_ready, b_ready, c_ready, d_ready;
    logic [15:0]      count;

    modport slave (
        input  in, in_valid, mode, in_sel,
        input  a_ready, b_ready, c_ready, d_ready,
        output in_ready, sel,
        output a, b, c, d,
        output a_valid, b_valid, c_valid, d_valid,
        output count
    );

    modport master (
        output in, in_valid, mode, in_sel,
        output a_ready, b_ready, c_ready, d_ready,
        input  in_ready, sel,
        input  a, b, c, d,
        input  a_valid, b_valid, c_valid, d_valid,
        input  count
    );
endinterface

// File: rtl/dispatch4way.sv
// One-to-four word dispatcher: round-robin or addressed routing into four
// single-entry channel registers, each drained by its own ready handshake.

// Single-word holding register for one output channel.
module dispatch4way_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             drdy,
    output logic [WIDTH-1:0] dout,
    output logic             dvld
);
    // Data is only written on load, so a drained channel keeps its last word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= '0;
            dvld <= 1'b0;
        end else if (load) begin
            dout <= din;
            dvld <= 1'b1;
        end else if (dvld && drdy) begin
            dvld <= 1'b0;
        end
    end
endmodule

module dispatch4way #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           reset,
    dispatch4way_if.slave  bus
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0][WIDTH-1:0] dat;
    logic [NUM_LANES-1:0]            vld;
    logic [NUM_LANES-1:0]            rdy;
    logic [NUM_LANES-1:0]            load;
    logic [1:0]                      rr;
    logic [1:0]                      sel;
    logic                            in_ready;
    logic                            accept;
    logic [15:0]                     count;

    assign rdy = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};

    // in_ready looks only at the target's occupancy, never at downstream ready,
    // so a stalled round-robin target blocks input rather than being skipped.
    assign sel      = bus.mode ? bus.in_sel : rr;
    assign in_ready = ~vld[sel];
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        load      = '0;
        load[sel] = accept;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dispatch4way_lane #(.WIDTH(WIDTH)) u_lane (
            .clk  (clk),
            .reset(reset),
            .load (load[i]),
            .din  (bus.in),
            .drdy (rdy[i]),
            .dout (dat[i]),
            .dvld (vld[i])
        );
    end

    // rr only moves on round-robin accepts; addressed traffic leaves it parked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr    <= 2'd0;
            count <= 16'd0;
        end else if (accept) begin
            count <= count + 16'd1;
            if (!bus.mode)
                rr <= rr + 2'd1;
        end
    end

    assign bus.sel      = sel;
    assign bus.in_ready = in_ready;
    assign bus.count    = count;
    assign bus.a        = dat[0];
    assign bus.b        = dat[1];
    assign bus.c        = dat[2];
    assign bus.d        = dat[3];
    assign bus.a_valid  = vld[0];
    assign bus.b_valid  = vld[1];
    assign bus.c_valid  = vld[2];
    assign bus.d_valid  = vld[3];
endmodule

// File: tb/tb_dispatch4way.sv
// Bench for dispatch4way: queue-free occupancy model checked every negedge,
// plus directed scenarios with literal expectations.
module tb_dispatch4way;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dispatch4way_if #(.WIDTH(16)) bus();

    dispatch4way #(.WIDTH(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Model state: what each channel holds, whether it is full, rr and count.
    logic [15:0] mdata [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
    bit          mfull [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int          mrr   = 0;
    int          mcount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [3:0] readies();
        return {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mdata[i] = 16'd0;
                mfull[i] = 1'b0;
            end
            mrr = 0;
            mcount = 0;
        end else begin
            int  t;
            bit  acc;
            bit [3:0] r;
            t   = bus.mode ? int'(bus.in_sel) : mrr;
            acc = bus.in_valid && !mfull[t];
            r   = readies();
            for (int i = 0; i < 4; i++)
                if (mfull[i] && r[i]) mfull[i] = 1'b0;
            if (acc) begin
                mdata[t] = bus.in;
                mfull[t] = 1'b1;
                mcount   = (mcount + 1) % 65536;
                if (!bus.mode) mrr = (mrr + 1) % 4;
            end
        end
    end

    task automatic check_model();
        int t;
        t = bus.mode ? int'(bus.in_sel) : mrr;
        chk("sel",      32'(bus.sel),      32'(t));
        chk("in_ready", 32'(bus.in_ready), 32'(!mfull[t]));
        chk("a",        32'(bus.a),        32'(mdata[0]));
        chk("b",        32'(bus.b),        32'(mdata[1]));
        chk("c",        32'(bus.c),        32'(mdata[2]));
        chk("d",        32'(bus.d),        32'(mdata[3]));
        chk("a_valid",  32'(bus.a_valid),  32'(mfull[0]));
        chk("b_valid",  32'(bus.b_valid),  32'(mfull[1]));
        chk("c_valid",  32'(bus.c_valid),  32'(mfull[2]));
        chk("d_valid",  32'(bus.d_valid),  32'(mfull[3]));
        chk("count",    32'(bus.count),    32'(mcount));
    endtask

    always @(negedge clk) check_model();

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit [3:0] r);
        {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = r;
    endtask

    task automatic send(input logic [15:0] w);
        bus.in = w;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.in = '0;
        bus.in_valid = 1'b0;
        bus.mode = 1'b0;
        bus.in_sel = 2'd0;
        set_ready(4'b0000);
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count",    32'(bus.count),    32'd0);
        // Offering a word while in reset must not be accepted.
        bus.in = 16'hDEAD;
        bus.in_valid = 1'b1;
        step();
        step();
        chk("rst_no_accept", 32'(bus.a_valid), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        step();

        // Four round-robin words fill a..d.
        for (int i = 1; i <= 4; i++) begin
            bus.in = 16'(i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_a", 32'(bus.a), 32'd1);
        chk("fill_b", 32'(bus.b), 32'd2);
        chk("fill_c", 32'(bus.c), 32'd3);
        chk("fill_d", 32'(bus.d), 32'd4);
        chk("fill_valids", 32'({bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid}), 32'hF);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_sel", 32'(bus.sel), 32'd0);
        chk("fill_in_ready", 32'(bus.in_ready), 32'd0);

        // Draining b does not unblock a stalled rr target of a.
        set_ready(4'b0010); step(); set_ready(4'b0000);
        chk("drain_b_valid", 32'(bus.b_valid), 32'd0);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("drain_b_hold", 32'(bus.b), 32'd2);
        set_ready(4'b0001); step(); set_ready(4'b0000);
        chk("drain_a_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'h0005);
        chk("w5_a", 32'(bus.a), 32'h5);
        chk("w5_count", 32'(bus.count), 32'd5);
        chk("w5_sel", 32'(bus.sel), 32'd1);

        // Addressed write into c; rr stays parked at b.
        set_ready(4'b0100); step(); set_ready(4'b0000);
        bus.mode = 1'b1;
        bus.in_sel = 2'b10;
        #1;
        chk("addr_sel_same_cycle", 32'(bus.sel), 32'd2);
        chk("addr_in_ready", 32'(bus.in_ready), 32'd1);
        send(16'hBEEF);
        chk("addr_c", 32'(bus.c), 32'hBEEF);
        chk("addr_c_valid", 32'(bus.c_valid), 32'd1);
        chk("addr_a_kept", 32'(bus.a), 32'h5);
        chk("addr_d_kept", 32'(bus.d), 32'h4);
        bus.mode = 1'b0;
        #1;
        chk("rr_held", 32'(bus.sel), 32'd1);

        // Drain c while an addressed accept lands in a in the same cycle.
        set_ready(4'b0001); step(); set_ready(4'b0000);
        bus.mode = 1'b1;
        bus.in_sel = 2'b00;
        set_ready(4'b0100);
        send(16'h1234);
        set_ready(4'b0000);
        chk("mix_c_valid", 32'(bus.c_valid), 32'd0);
        chk("mix_a_valid", 32'(bus.a_valid), 32'd1);
        chk("mix_a", 32'(bus.a), 32'h1234);
        chk("mix_count", 32'(bus.count), 32'd7);

        // Counter wrap: fresh reset, then 65536 back-to-back accepts.
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        bus.mode = 1'b0;
        set_ready(4'b1111);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus.in = 16'(i);
            step();
        end
        chk("pre_wrap_count", 32'(bus.count), 32'hFFFF);
        chk("pre_wrap_sel", 32'(bus.sel), 32'd3);
        bus.in = 16'hAAAA;
        step();
        bus.in_valid = 1'b0;
        chk("wrap_count", 32'(bus.count), 32'd0);
        chk("wrap_sel", 32'(bus.sel), 32'd0);
        step();
        set_ready(4'b0000);

        // Fill three channels, then reset between edges.
        for (int i = 0; i < 3; i++) send(16'h0100 + 16'(i));
        chk("pre_rst_valids", 32'({bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid}), 32'h7);
        #2 reset = 1'b1;
        #1;
        chk("async_valids", 32'({bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid}), 32'h0);
        chk("async_data", 32'(bus.a | bus.b | bus.c | bus.d), 32'h0);
        chk("async_count", 32'(bus.count), 32'd0);
        chk("async_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        reset = 1'b0;
        send(16'h0077);
        chk("post_rst_a", 32'(bus.a), 32'h77);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
